// File: rtl/switch_xbar_dbuf_pkg.sv
// Shared constants and helpers for the NIN x NOUT switch cell.
// Field layout: bit 0 is reg_mode, the bits above it are sel.
package switch_pkg;

  function automatic int sel_width(input int nin);
    return $clog2(nin + 1);
  endfunction

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NIN   = 16;
  localparam int DEF_NOUT  = 4;
  localparam int DEF_SEL_W = sel_width(DEF_NIN);
  localparam int DEF_FLD_W = DEF_SEL_W + 1;
  localparam int DEF_CFG_W = DEF_NOUT * DEF_FLD_W;

  localparam int REG_MODE_BIT = 0;
  localparam int SEL_LSB      = 1;

endpackage

// File: rtl/switch_xbar_dbuf_out_slice.sv
// One output lane: input mux, capture register, mode select.
// Out-of-range selects (including all-ones) drive zero/invalid.
module switch_out_slice #(
  parameter int WIDTH = 32,
  parameter int NIN   = 16,
  parameter int SEL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIN*WIDTH-1:0] in_data,
  input  logic [NIN-1:0]       in_valid,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 reg_mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid
);

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic [WIDTH-1:0] out_reg;
  logic             out_vreg;

  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      if (sel == SEL_W'(i)) begin
        m_data  = in_data[i*WIDTH +: WIDTH];
        m_valid = in_valid[i];
      end
    end
  end

  // Captured every edge so a mode switch shows the prior-cycle result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg  <= '0;
      out_vreg <= 1'b0;
    end else begin
      out_reg  <= m_data;
      out_vreg <= m_valid;
    end
  end

  assign out_data  = reg_mode ? out_reg  : m_data;
  assign out_valid = reg_mode ? out_vreg : m_valid;

endmodule

// File: rtl/switch_xbar_dbuf.sv
// Switch cell top: double-buffered serial config chain
// (shadow shifts, active commits on config_load) plus output slices.
module switch_xbar_dbuf
  import switch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NIN   = DEF_NIN,
  parameter int NOUT  = DEF_NOUT
) (
  input  logic                  config_clk,
  input  logic                  config_reset,
  input  logic                  config_en,
  input  logic                  config_in,
  output logic                  config_out,
  input  logic                  config_load,
  input  logic [NIN*WIDTH-1:0]  in_data,
  input  logic [NIN-1:0]        in_valid,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid
);

  localparam int SEL_W = sel_width(NIN);
  localparam int FLD_W = SEL_W + 1;
  localparam int CFG_W = NOUT * FLD_W;

  function automatic logic [CFG_W-1:0] cfg_rst();
    logic [CFG_W-1:0] r;
    r = '0;
    for (int k = 0; k < NOUT; k++) begin
      r[k*FLD_W+SEL_LSB +: SEL_W] = '1;
    end
    return r;
  endfunction

  localparam logic [CFG_W-1:0] ACT_RST = cfg_rst();

  logic [CFG_W-1:0] shadow;
  logic [CFG_W-1:0] active;

  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      shadow <= '0;
    end else if (config_en) begin
      shadow <= {config_in, shadow[CFG_W-1:1]};
    end
  end

  // Commit takes the pre-edge shadow even while it is shifting.
  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      active <= ACT_RST;
    end else if (config_load) begin
      active <= shadow;
    end
  end

  assign config_out = shadow[0];

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    switch_out_slice #(
      .WIDTH (WIDTH),
      .NIN   (NIN),
      .SEL_W (SEL_W)
    ) u_slice (
      .clk       (config_clk),
      .rst       (config_reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .sel       (active[k*FLD_W+SEL_LSB +: SEL_W]),
      .reg_mode  (active[k*FLD_W+REG_MODE_BIT]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .out_valid (out_valid[k])
    );
  end

endmodule

// File: tb/tb_switch_xbar_dbuf.sv
// Directed bench for switch_xbar_dbuf (NIN=16, NOUT=4, WIDTH=32).
// Expected values are hand-derived constants.
module tb_switch_xbar_dbuf;

  localparam int W = 32;
  localparam int NI = 16;
  localparam int NO = 4;
  localparam int CW = 24;

  logic            clk;
  logic            rst;
  logic            cen;
  logic            cin;
  logic            cout;
  logic            cload;
  logic [NI*W-1:0] in_data;
  logic [NI-1:0]   in_valid;
  logic [NO*W-1:0] out_data;
  logic [NO-1:0]   out_valid;

  int n_cmp;
  int n_err;

  localparam logic [CW-1:0] C1 =
    {6'h3E, 6'h20, 6'h1F, 6'h06};
  localparam logic [CW-1:0] C2 =
    {6'h0E, 6'h0E, 6'h0E, 6'h0E};
  localparam logic [CW-1:0] C3 =
    {6'h0E, 6'h0E, 6'h0E, 6'h04};
  localparam logic [CW-1:0] C4 =
    {6'h0E, 6'h0E, 6'h0E, 6'h0B};

  switch_xbar_dbuf #(
    .WIDTH (W),
    .NIN   (NI),
    .NOUT  (NO)
  ) dut (
    .config_clk   (clk),
    .config_reset (rst),
    .config_en    (cen),
    .config_in    (cin),
    .config_out   (cout),
    .config_load  (cload),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic set_in(input int i,
                        input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic shift_cfg(input logic [CW-1:0] c,
                           input bit do_chk,
                           input logic [CW-1:0] prev,
                           input logic [127:0] eo,
                           input logic [3:0] ev);
    for (int i = 0; i < CW; i++) begin
      cen = 1'b1;
      cin = c[i];
      #1;
      if (do_chk) begin
        chk("shift_cfg_out", 128'(cout),
            128'(prev[i]));
        chk("shift_data", out_data, eo);
        chk("shift_valid", 128'(out_valid),
            128'(ev));
      end
      @(posedge clk);
      #1;
    end
    cen = 1'b0;
    cin = 1'b0;
  endtask

  task automatic load;
    cload = 1'b1;
    @(posedge clk);
    #1;
    cload = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    cen = 1'b0;
    cin = 1'b0;
    cload = 1'b0;
    in_valid = '1;
    for (int i = 0; i < NI; i++)
      set_in(i, 32'h1111_0000 | W'(i));

    // 1. reset with non-zero inputs
    #2 rst = 1'b1;
    #2;
    chk("rst_data", out_data, 128'h0);
    chk("rst_valid", 128'(out_valid), 128'h0);
    chk("rst_cfg_out", 128'(cout), 128'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_data", out_data, 128'h0);
      chk("post_rst_valid", 128'(out_valid), 128'h0);
    end

    // 2. first config
    shift_cfg(C1, 1'b0, '0, '0, '0);
    chk("pre_load_data", out_data, 128'h0);
    load();
    set_in(3, 32'hA5A5_A5A5);
    set_in(15, 32'h0000_1234);
    #1;
    chk("cfg1_data_t0", out_data,
        {32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5});
    chk("cfg1_valid_t0", 128'(out_valid),
        128'(4'b0001));
    @(posedge clk);
    #1;
    chk("cfg1_data_t1", out_data,
        {32'h0, 32'h0, 32'h1234, 32'hA5A5_A5A5});
    chk("cfg1_valid_t1", 128'(out_valid),
        128'(4'b0011));

    // 3. shift without load: outputs frozen
    shift_cfg(C2, 1'b1, C1,
              {32'h0, 32'h0, 32'h1234, 32'hA5A5_A5A5},
              4'b0011);
    chk("dbuf_shadow", 128'(dut.shadow), 128'(C2));

    // 4. shift and load in the same edge
    cen = 1'b1;
    cin = 1'b1;
    cload = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0;
    cin = 1'b0;
    cload = 1'b0;
    chk("same_active", 128'(dut.active), 128'(C2));
    chk("same_shadow", 128'(dut.shadow),
        128'({1'b1, C2[CW-1:1]}));
    chk("same_cfg_out", 128'(cout), 128'h1);

    // 5. broadcast of input 7
    chk("bcast_data0", out_data, {4{32'h1111_0007}});
    set_in(7, 32'hCAFE_F00D);
    #1;
    chk("bcast_data1", out_data, {4{32'hCAFE_F00D}});
    chk("bcast_valid1", 128'(out_valid),
        128'(4'b1111));
    in_valid[7] = 1'b0;
    #1;
    chk("bcast_valid0", 128'(out_valid), 128'h0);
    in_valid[7] = 1'b1;
    #1;
    chk("bcast_valid2", 128'(out_valid),
        128'(4'b1111));

    // 6. out0 comb sel 2 -> reg sel 5
    shift_cfg(C3, 1'b0, '0, '0, '0);
    load();
    chk("c3_data", out_data,
        {{3{32'hCAFE_F00D}}, 32'h1111_0002});
    shift_cfg(C4, 1'b1, C3,
              {{3{32'hCAFE_F00D}}, 32'h1111_0002},
              4'b1111);
    set_in(2, 32'h2222_2222);
    set_in(5, 32'h5555_5555);
    load();
    chk("mode_t0", out_data,
        {{3{32'hCAFE_F00D}}, 32'h2222_2222});
    set_in(2, 32'hDEAD_0002);
    #1;
    chk("mode_t0_hold", out_data,
        {{3{32'hCAFE_F00D}}, 32'h2222_2222});
    @(posedge clk);
    #1;
    chk("mode_t1", out_data,
        {{3{32'hCAFE_F00D}}, 32'h5555_5555});
    chk("mode_t1_valid", 128'(out_valid),
        128'(4'b1111));

    // mid-cycle reset with live outputs
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_data", out_data, 128'h0);
    chk("mid_rst_valid", 128'(out_valid), 128'h0);
    chk("mid_rst_cfg_out", 128'(cout), 128'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", out_data, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("after_rst_data", out_data, 128'h0);
      chk("after_rst_valid", 128'(out_valid),
          128'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
